// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer: CHANNELS independent WIDTH-bit up/down counters with auto-reload,
// sticky W1C status and level interrupts, sharing one free-running prescaler.

module apb_timer_ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       psc_i,
    input  logic             wr_tdr_i,
    input  logic             wr_tcr_i,
    input  logic             wr_tsr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] tdr_o,
    output logic [7:0]       tcr_o,
    output logic [1:0]       tsr_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             irq_o
);
    logic [WIDTH-1:0] tdr_q, cnt_q, cnt_d;
    logic [7:0]       tcr_q;
    logic [1:0]       tsr_q, tsr_d, set_flag;
    logic             irq_q, irq_d;
    logic [3:0]       mask;
    logic             tick;

    // TCR fields: [7] LOAD [6] ARL [5] DIR [4] EN [3] UIE [2] OIE [1:0] CKS
    always_comb begin
        mask = 4'b0001;
        case (tcr_q[1:0])
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        tick = ((psc_i & mask) == mask);
    end

    always_comb begin
        cnt_d    = cnt_q;
        set_flag = 2'b00;
        if (tcr_q[7]) begin
            cnt_d = tdr_q;
        end else if (tcr_q[4] && tick) begin
            if (!tcr_q[5]) begin
                if (&cnt_q) begin
                    set_flag[0] = 1'b1;
                    cnt_d       = tcr_q[6] ? tdr_q : '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    set_flag[1] = 1'b1;
                    cnt_d       = tcr_q[6] ? tdr_q : '1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
        // hardware set is OR-ed after the W1C mask so it wins a same-cycle clear
        tsr_d = (tsr_q & ~(wr_tsr_i ? wdata_i[1:0] : 2'b00)) | set_flag;
        irq_d = (tsr_q[0] & tcr_q[2]) | (tsr_q[1] & tcr_q[3]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdr_q <= '0;
            tcr_q <= '0;
            tsr_q <= '0;
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr_tdr_i) tdr_q <= wdata_i;
            if (wr_tcr_i) tcr_q <= wdata_i[7:0];
            tsr_q <= tsr_d;
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    assign tdr_o = tdr_q;
    assign tcr_o = tcr_q;
    assign tsr_o = tsr_q;
    assign cnt_o = cnt_q;
    assign irq_o = irq_q;
endmodule

module apb_timer_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int PDATA_W     = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [PDATA_W-1:0]  pwdata,
    output logic [PDATA_W-1:0]  prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [CHANNELS-1:0] irq
);
    localparam int CHW = ADDR_W - 2;
    localparam int WCW = $clog2(WAIT_STATES + 2);
    localparam logic [WCW-1:0] WS_LAST = WCW'(WAIT_STATES);
    localparam logic [WCW-1:0] WS_DONE = WCW'(WAIT_STATES + 1);

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [3:0]     psc_q;
    logic           access, err, commit;
    logic [CHW-1:0] ch;
    logic [1:0]     rsel;
    logic           unused_pwdata;

    logic [CHANNELS-1:0][WIDTH-1:0] tdr, cnt;
    logic [CHANNELS-1:0][7:0]       tcr;
    logic [CHANNELS-1:0][1:0]       tsr;

    assign access  = psel & penable;
    assign ch      = paddr[ADDR_W-1:2];
    assign rsel    = paddr[1:0];
    assign err     = (32'(ch) >= 32'(CHANNELS)) | (pwrite & (rsel == 2'd3));
    assign pready  = access & (wcnt_q == WS_LAST);
    assign pslverr = pready & err;
    assign commit  = pready & pwrite & ~err;
    assign unused_pwdata = ^pwdata;

    // WS_DONE parks the counter after pready (or reset) until the access phase ends
    always_comb begin
        wcnt_d = wcnt_q;
        if (!access)                wcnt_d = '0;
        else if (wcnt_q == WS_LAST) wcnt_d = WS_DONE;
        else if (wcnt_q != WS_DONE) wcnt_d = wcnt_q + WCW'(1);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wcnt_q <= WS_DONE;
            psc_q  <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            psc_q  <= psc_q + 4'd1;
        end
    end

    always_comb begin
        prdata = '0;
        if (pready && !err && !pwrite) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch == CHW'(c)) begin
                    case (rsel)
                        2'd0:    prdata = PDATA_W'(tdr[c]);
                        2'd1:    prdata = PDATA_W'(tcr[c]);
                        2'd2:    prdata = PDATA_W'(tsr[c]);
                        default: prdata = PDATA_W'(cnt[c]);
                    endcase
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic sel;
        assign sel = commit && (ch == CHW'(c));
        apb_timer_ch #(.WIDTH(WIDTH)) u_ch (
            .clk_i    (pclk),
            .rst_i    (preset),
            .psc_i    (psc_q),
            .wr_tdr_i (sel && (rsel == 2'd0)),
            .wr_tcr_i (sel && (rsel == 2'd1)),
            .wr_tsr_i (sel && (rsel == 2'd2)),
            .wdata_i  (pwdata[WIDTH-1:0]),
            .tdr_o    (tdr[c]),
            .tcr_o    (tcr[c]),
            .tsr_o    (tsr[c]),
            .cnt_o    (cnt[c]),
            .irq_o    (irq[c])
        );
    end
endmodule

// File: tb/tb_apb_timer_multi.sv
// Directed bench: u0 with no wait states, u1 with WAIT_STATES=2 for wait-state and W1C race checks.
module tb_apb_timer_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             preset;
    logic [1:0]       psel, penable, pwrite, pready, pslverr;
    logic [1:0][7:0]  paddr;
    logic [1:0][31:0] pwdata, prdata;
    logic [1:0][3:0]  irq;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned ecount;

    apb_timer_multi #(.CHANNELS(4), .WIDTH(8), .PDATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) u0 (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .irq(irq[0]));

    apb_timer_multi #(.CHANNELS(4), .WIDTH(8), .PDATA_W(32), .ADDR_W(8), .WAIT_STATES(2)) u1 (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .irq(irq[1]));

    // Edges since reset release: equals the prescaler phase, used to aim transfers at tick edges
    always @(posedge clk) begin
        if (preset) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          exp_err;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] e, input bit er);
        vec_t v;
        v = '{w, a, d, e, er};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge
    task automatic apb(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int cyc);
        bit done;
        done = 1'b0;
        rd = '0; er = 1'b0; cyc = 0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            #2;
            cyc++;
            if (pready[d]) begin
                rd = prdata[d]; er = pslverr[d]; done = 1'b1;
            end
            @(posedge clk); #1;
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL apb_timeout: dut %0d addr %0h got no pready, want pready within 16", d, a);
        end
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [31:0] wd);
        logic [31:0] r; logic e; int c;
        apb(d, 1'b1, a, wd, r, e, c);
    endtask

    task automatic rd_chk(input int d, input logic [7:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] r; logic e; int c;
        apb(d, 1'b0, a, '0, r, e, c);
        chk(nm, r, exp);
    endtask

    task automatic wait_psc(input logic [3:0] m, input logic [3:0] val);
        int n;
        n = 0;
        while (((ecount[3:0] & m) != val) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_psc: phase %0h not reached, want %0h", ecount[3:0], val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want summary first");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          c;
        logic [7:0]  up_exp [4];
        logic [7:0]  dn_exp [10];

        up_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        dn_exp = '{8'h03, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03, 8'h02};

        // reset state, TC08 regression, error responses, field widths
        add(0, 8'h00, 0, 32'h00, 0); add(0, 8'h01, 0, 32'h00, 0);
        add(0, 8'h02, 0, 32'h00, 0); add(0, 8'h03, 0, 32'h00, 0);
        add(0, 8'h0D, 0, 32'h00, 0); add(0, 8'h0F, 0, 32'h00, 0);
        add(1, 8'h00, 32'hFF, 0, 0); add(1, 8'h01, 32'h80, 0, 0);
        add(1, 8'h00, 32'h00, 0, 0); add(1, 8'h01, 32'h80, 0, 0);
        add(0, 8'h03, 0, 32'h00, 0); add(0, 8'h02, 0, 32'h00, 0);
        add(0, 8'h01, 0, 32'h80, 0); add(1, 8'h01, 32'h00, 0, 0);
        add(0, 8'h10, 0, 32'h00, 1); add(0, 8'h13, 0, 32'h00, 1);
        add(1, 8'h03, 32'h55, 0, 1); add(0, 8'h03, 0, 32'h00, 0);
        add(1, 8'h10, 32'hAA, 0, 1); add(1, 8'h3C, 32'hAA, 0, 1);
        add(0, 8'h00, 0, 32'h00, 0);
        add(1, 8'h0C, 32'h1234, 0, 0); add(0, 8'h0C, 0, 32'h34, 0);
        add(1, 8'h0D, 32'hF0A, 0, 0);  add(0, 8'h0D, 0, 32'h0A, 0);
        add(1, 8'h0E, 32'h03, 0, 0);   add(0, 8'h0E, 0, 32'h00, 0);

        preset = 1'b1; psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
        repeat (2) @(posedge clk);
        #1 preset = 1'b0;
        #2;
        chk("reset_irq0", {28'b0, irq[0]}, 32'h0);
        chk("reset_irq1", {28'b0, irq[1]}, 32'h0);
        chk("reset_pready", {30'b0, pready}, 32'h0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            apb(0, tbl[i].wr, tbl[i].addr, tbl[i].data, r, e, c);
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
            if (!tbl[i].wr) chk($sformatf("vec%0d_data", i), r, tbl[i].exp);
            if (i == 0) chk("ws0_access_cycles", c, 1);
        end

        // up overflow on ch1, commit aligned so the first tick lands two edges later
        wr(0, 8'h04, 32'hFE);
        wr(0, 8'h05, 32'h80);
        wait_psc(4'h1, 4'h0);
        wr(0, 8'h05, 32'h14);
        for (int k = 0; k < 4; k++) rd_chk(0, 8'h07, {24'b0, up_exp[k]}, $sformatf("up_cnt%0d", k));
        rd_chk(0, 8'h06, 32'h01, "up_tsr");
        chk("up_irq_set", {31'b0, irq[0][1]}, 32'h1);
        wr(0, 8'h06, 32'h01);
        chk("up_irq_lag", {31'b0, irq[0][1]}, 32'h1);
        @(posedge clk); #1;
        chk("up_irq_clr", {31'b0, irq[0][1]}, 32'h0);
        rd_chk(0, 8'h06, 32'h00, "up_tsr_clr");
        wr(0, 8'h05, 32'h00);

        // down count with auto-reload on ch2, CKS=1 (tick every 4 clocks)
        wr(0, 8'h08, 32'h03);
        wr(0, 8'h09, 32'h80);
        wait_psc(4'h3, 4'h0);
        wr(0, 8'h09, 32'h79);
        for (int k = 0; k < 10; k++) rd_chk(0, 8'h0B, {24'b0, dn_exp[k]}, $sformatf("dn_cnt%0d", k));
        rd_chk(0, 8'h0A, 32'h02, "dn_tsr");
        chk("dn_irq", {28'b0, irq[0]}, 32'h4);
        wr(0, 8'h09, 32'h00);

        // wait states: pready after exactly three access cycles
        apb(1, 1'b0, 8'h00, '0, r, e, c);
        chk("ws2_rd_cycles", c, 3);
        chk("ws2_rd_data", r, 32'h0);
        apb(1, 1'b1, 8'h00, 32'hFF, r, e, c);
        chk("ws2_wr_cycles", c, 3);

        // ch0 overflows on every CKS=3 tick (psc==15); aim a W1C commit at that edge
        wr(1, 8'h01, 32'h80);
        wr(1, 8'h01, 32'h57);
        wait_psc(4'hF, 4'hC);
        wr(1, 8'h02, 32'h01);
        rd_chk(1, 8'h02, 32'h01, "race_ovf_kept");
        chk("race_irq", {31'b0, irq[1][0]}, 32'h1);
        wait_psc(4'hF, 4'h0);
        wr(1, 8'h02, 32'h01);
        rd_chk(1, 8'h02, 32'h00, "w1c_off_tick");
        wr(1, 8'h01, 32'h00);

        // reset during an access phase
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 8'h00;
        @(posedge clk); #1;
        penable[1] = 1'b1; preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        #2;
        chk("rst_abort_pready", {31'b0, pready[1]}, 32'h0);
        chk("rst_irq0", {28'b0, irq[0]}, 32'h0);
        chk("rst_irq1", {28'b0, irq[1]}, 32'h0);
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        rd_chk(0, 8'h04, 32'h00, "rst_tdr1");
        rd_chk(0, 8'h0A, 32'h00, "rst_tsr2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
